// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encoding, bit order and opcode helpers shared across JTAG blocks
package jtag_pkg;
  typedef logic [15:0] tap_state_t;
  localparam int TLR      = 15;
  localparam int RTI      = 14;
  localparam int SEL_DR   = 13;
  localparam int CAP_DR   = 12;
  localparam int SHIFT_DR = 11;
  localparam int EXIT1_DR = 10;
  localparam int PAUSE_DR = 9;
  localparam int EXIT2_DR = 8;
  localparam int UPD_DR   = 7;
  localparam int SEL_IR   = 6;
  localparam int CAP_IR   = 5;
  localparam int SHIFT_IR = 4;
  localparam int EXIT1_IR = 3;
  localparam int PAUSE_IR = 2;
  localparam int EXIT2_IR = 1;
  localparam int UPD_IR   = 0;
  localparam tap_state_t S_TLR      = tap_state_t'(1) << TLR;
  localparam tap_state_t S_RTI      = tap_state_t'(1) << RTI;
  localparam tap_state_t S_SEL_DR   = tap_state_t'(1) << SEL_DR;
  localparam tap_state_t S_CAP_DR   = tap_state_t'(1) << CAP_DR;
  localparam tap_state_t S_SHIFT_DR = tap_state_t'(1) << SHIFT_DR;
  localparam tap_state_t S_EXIT1_DR = tap_state_t'(1) << EXIT1_DR;
  localparam tap_state_t S_PAUSE_DR = tap_state_t'(1) << PAUSE_DR;
  localparam tap_state_t S_EXIT2_DR = tap_state_t'(1) << EXIT2_DR;
  localparam tap_state_t S_UPD_DR   = tap_state_t'(1) << UPD_DR;
  localparam tap_state_t S_SEL_IR   = tap_state_t'(1) << SEL_IR;
  localparam tap_state_t S_CAP_IR   = tap_state_t'(1) << CAP_IR;
  localparam tap_state_t S_SHIFT_IR = tap_state_t'(1) << SHIFT_IR;
  localparam tap_state_t S_EXIT1_IR = tap_state_t'(1) << EXIT1_IR;
  localparam tap_state_t S_PAUSE_IR = tap_state_t'(1) << PAUSE_IR;
  localparam tap_state_t S_EXIT2_IR = tap_state_t'(1) << EXIT2_IR;
  localparam tap_state_t S_UPD_IR   = tap_state_t'(1) << UPD_IR;
  function automatic logic [31:0] bypass_op(int w);
    return 32'((64'd1 << w) - 64'd1);
  endfunction
endpackage

// File: rtl/jtag_tap_ir_if.sv
// jtag_tap_ir_if: pad-side JTAG signals plus user-chain strobes and serial returns
interface jtag_tap_ir_if #(
  parameter int IR_WIDTH = 4,
  parameter int N_USER   = 4
);
  logic                tms;
  logic                tdi;
  logic                tdo;
  logic                tdo_en;
  logic [15:0]         tap_state;
  logic [IR_WIDTH-1:0] ir;
  logic [N_USER-1:0]   user_sel;
  logic [N_USER-1:0]   user_tdo;
  logic                capture_dr;
  logic                shift_dr;
  logic                update_dr;
  modport master (output tms, tdi, user_tdo,
                  input tdo, tdo_en, tap_state, ir, user_sel, capture_dr, shift_dr, update_dr);
  modport slave (input tms, tdi, user_tdo,
                 output tdo, tdo_en, tap_state, ir, user_sel, capture_dr, shift_dr, update_dr);
endinterface

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: 16-state one-hot TAP controller; illegal encodings fall back to TLR
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_t tap_state
);
  tap_state_t state_q, state_d;
  always_ff @(posedge tck or posedge trst)
    if (trst) state_q <= S_TLR;
    else state_q <= state_d;
  always_comb begin
    state_d = S_TLR;
    case (state_q)
      S_TLR:      state_d = tms ? S_TLR      : S_RTI;
      S_RTI:      state_d = tms ? S_SEL_DR   : S_RTI;
      S_SEL_DR:   state_d = tms ? S_SEL_IR   : S_CAP_DR;
      S_CAP_DR:   state_d = tms ? S_EXIT1_DR : S_SHIFT_DR;
      S_SHIFT_DR: state_d = tms ? S_EXIT1_DR : S_SHIFT_DR;
      S_EXIT1_DR: state_d = tms ? S_UPD_DR   : S_PAUSE_DR;
      S_PAUSE_DR: state_d = tms ? S_EXIT2_DR : S_PAUSE_DR;
      S_EXIT2_DR: state_d = tms ? S_UPD_DR   : S_SHIFT_DR;
      S_UPD_DR:   state_d = tms ? S_SEL_DR   : S_RTI;
      S_SEL_IR:   state_d = tms ? S_TLR      : S_CAP_IR;
      S_CAP_IR:   state_d = tms ? S_EXIT1_IR : S_SHIFT_IR;
      S_SHIFT_IR: state_d = tms ? S_EXIT1_IR : S_SHIFT_IR;
      S_EXIT1_IR: state_d = tms ? S_UPD_IR   : S_PAUSE_IR;
      S_PAUSE_IR: state_d = tms ? S_EXIT2_IR : S_PAUSE_IR;
      S_EXIT2_IR: state_d = tms ? S_UPD_IR   : S_SHIFT_IR;
      S_UPD_IR:   state_d = tms ? S_SEL_DR   : S_RTI;
      default:    state_d = S_TLR;
    endcase
  end
  always_comb tap_state = state_q;
endmodule

// File: rtl/jtag_tap_ir.sv
// jtag_tap_ir: TAP with instruction register, BYPASS/IDCODE DRs, user DR channels
// and negedge-retimed TDO for the DCD/DHP test interface.
module jtag_tap_ir
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH      = 4,
  parameter logic [31:0]         IDCODE_VALUE  = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0] IDCODE_OPCODE = 4'b0001,
  parameter int                  N_USER        = 4,
  parameter logic [IR_WIDTH-1:0] USER_BASE     = 4'b0100
)(
  input logic         tck,
  input logic         trst,
  jtag_tap_ir_if.slave bus
);
  localparam logic [IR_WIDTH-1:0] BYPASS_OP = IR_WIDTH'(bypass_op(IR_WIDTH));
  tap_state_t          st;
  logic [IR_WIDTH-1:0] ir_q, ir_d, ir_sr_q, ir_sr_d;
  logic [31:0]         id_q, id_d;
  logic                byp_q, byp_d, tdo_q, tdo_d, tdo_en_q, tdo_en_d;
  logic                is_id, dr_tdo;
  logic [N_USER-1:0]   user_sel;
  jtag_tap_fsm u_fsm (.tck(tck), .trst(trst), .tms(bus.tms), .tap_state(st));
  // All-ones wins over every other decode; unknown opcodes fall through to BYPASS
  always_comb begin
    is_id = ir_q != BYPASS_OP && ir_q == IDCODE_OPCODE;
    for (int k = 0; k < N_USER; k++)
      user_sel[k] = ir_q != BYPASS_OP && !is_id && ir_q == USER_BASE + IR_WIDTH'(k);
    dr_tdo   = is_id ? id_q[0] : |user_sel ? |(user_sel & bus.user_tdo) : byp_q;
    ir_d     = st[TLR] ? IDCODE_OPCODE : st[UPD_IR] ? ir_sr_q : ir_q;
    ir_sr_d  = st[CAP_IR] ? IR_WIDTH'(1) : st[SHIFT_IR] ? {bus.tdi, ir_sr_q[IR_WIDTH-1:1]} : ir_sr_q;
    byp_d    = st[CAP_DR] ? 1'b0 : st[SHIFT_DR] ? bus.tdi : byp_q;
    id_d     = st[CAP_DR] ? IDCODE_VALUE : st[SHIFT_DR] ? {bus.tdi, id_q[31:1]} : id_q;
    tdo_en_d = st[SHIFT_IR] | st[SHIFT_DR];
    tdo_d    = st[SHIFT_IR] ? ir_sr_q[0] : st[SHIFT_DR] ? dr_tdo : tdo_q;
  end
  always_ff @(posedge tck or posedge trst)
    if (trst) begin
      ir_q    <= IDCODE_OPCODE;
      ir_sr_q <= '0;
      id_q    <= '0;
      byp_q   <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      ir_sr_q <= ir_sr_d;
      id_q    <= id_d;
      byp_q   <= byp_d;
    end
  always_ff @(negedge tck or posedge trst)
    if (trst) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  assign bus.tap_state  = st;
  assign bus.ir         = ir_q;
  assign bus.user_sel   = user_sel;
  assign bus.capture_dr = st[CAP_DR] & |user_sel;
  assign bus.shift_dr   = st[SHIFT_DR] & |user_sel;
  assign bus.update_dr  = st[UPD_DR] & |user_sel;
  assign bus.tdo        = tdo_q;
  assign bus.tdo_en     = tdo_en_q;
endmodule

// File: tb/tb_jtag_tap_ir.sv
// tb_jtag_tap_ir: directed and randomized scans against a bit-level behavioural model
module tb_jtag_tap_ir;
  localparam int W  = 4;
  localparam int NU = 4;
  localparam logic [31:0] IDV = 32'h1000_0001;
  logic tck = 1'b0;
  logic trst = 1'b1;
  int checks = 0;
  int passed = 0;
  logic [NU-1:0] hist [64];
  int nc, ns, nu;
  jtag_tap_ir_if #(.IR_WIDTH(W), .N_USER(NU)) bus ();
  jtag_tap_ir #(.IR_WIDTH(W), .IDCODE_VALUE(IDV), .IDCODE_OPCODE(4'b0001),
                .N_USER(NU), .USER_BASE(4'b0100)) dut (.tck(tck), .trst(trst), .bus(bus.slave));
  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input logic m, input logic d);
    bus.tms = m;
    bus.tdi = d;
    bus.user_tdo = NU'($urandom);
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  task automatic cnt();
    nc += int'(bus.capture_dr);
    ns += int'(bus.shift_dr);
    nu += int'(bus.update_dr);
  endtask

  // Starts and ends in Run-Test/Idle; returns the 4 bits seen on tdo during SHIFT_IR
  task automatic load_ir(input logic [W-1:0] val, output logic [W-1:0] cap);
    cap = '0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < W; i++) begin
      cap[i] = bus.tdo;
      step(i == W - 1, val[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] out, output logic held);
    out = '0;
    nc = 0; ns = 0; nu = 0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0); cnt();
    step(1'b0, 1'b0); cnt();
    chk("tdo_en_in_shift", 64'(bus.tdo_en), 64'd1);
    for (int i = 0; i < n; i++) begin
      out[i] = bus.tdo;
      hist[i] = bus.user_tdo;
      step(i == n - 1, din[i]);
      cnt();
    end
    chk("tdo_en_after_shift", 64'(bus.tdo_en), 64'd0);
    held = bus.tdo;
    step(1'b1, 1'b0); cnt();
    step(1'b0, 1'b0); cnt();
  endtask

  // What tdo must show for n shifted bits, derived from the instruction meaning
  function automatic logic [63:0] exp_dr(input logic [W-1:0] op, input int n, input logic [63:0] din);
    logic [63:0] e = '0;
    logic [31:0] idv = IDV;
    for (int i = 0; i < n; i++)
      if (op == 4'b0001) e[i] = i < 32 ? idv[i] : din[i-32];
      else if (op >= 4'd4 && op <= 4'd7) e[i] = hist[i][int'(op) - 4];
      else e[i] = i == 0 ? 1'b0 : din[i-1];
    return e;
  endfunction

  task automatic run_dr(input string tag, input logic [W-1:0] op, input int n);
    logic [63:0] din, out, e;
    logic held;
    bit usr;
    din = {$urandom, $urandom};
    scan_dr(n, din, out, held);
    e = exp_dr(op, n, din);
    usr = op >= 4'd4 && op <= 4'd7;
    chk({tag, "_tdo"}, out, e);
    chk({tag, "_hold"}, 64'(held), 64'(e[n-1]));
    chk({tag, "_capture_cnt"}, 64'(nc), usr ? 64'd1 : 64'd0);
    chk({tag, "_shift_cnt"}, 64'(ns), usr ? 64'(n) : 64'd0);
    chk({tag, "_update_cnt"}, 64'(nu), usr ? 64'd1 : 64'd0);
  endtask

  initial begin
    logic [W-1:0] cap, op;
    logic [63:0] out;
    logic held;
    logic [NU-1:0] esel;
    bus.tms = 1'b1;
    bus.tdi = 1'b0;
    bus.user_tdo = '0;
    #12;
    chk("rst_state", 64'(bus.tap_state), 64'h8000);
    chk("rst_ir", 64'(bus.ir), 64'h1);
    chk("rst_user_sel", 64'(bus.user_sel), 64'h0);
    chk("rst_tdo", 64'(bus.tdo), 64'h0);
    chk("rst_tdo_en", 64'(bus.tdo_en), 64'h0);
    chk("rst_strobes", 64'({bus.capture_dr, bus.shift_dr, bus.update_dr}), 64'h0);
    trst = 1'b0;
    step(1'b0, 1'b0);
    chk("rti_state", 64'(bus.tap_state), 64'h4000);
    run_dr("idcode", 4'b0001, 40);
    load_ir(4'b1111, cap);
    chk("ir_capture_f", 64'(cap), 64'h1);
    chk("ir_f", 64'(bus.ir), 64'hF);
    scan_dr(5, 64'h0D, out, held);
    chk("bypass_1011", out, 64'h1A);
    load_ir(4'b0000, cap);
    chk("ir_capture_0", 64'(cap), 64'h1);
    chk("ir_0", 64'(bus.ir), 64'h0);
    chk("ir_0_user_sel", 64'(bus.user_sel), 64'h0);
    run_dr("bypass_ir0", 4'b0000, 10);
    load_ir(4'b0110, cap);
    chk("user2_sel", 64'(bus.user_sel), 64'h4);
    run_dr("user2", 4'b0110, 12);
    load_ir(4'b1010, cap);
    chk("undecoded_sel", 64'(bus.user_sel), 64'h0);
    run_dr("undecoded", 4'b1010, 9);
    for (int t = 0; t < 10; t++) begin
      op = W'($urandom_range(0, 15));
      load_ir(op, cap);
      chk("rand_ir_capture", 64'(cap), 64'h1);
      chk("rand_ir", 64'(bus.ir), 64'(op));
      esel = (op >= 4'd4 && op <= 4'd7) ? NU'(1) << (int'(op) - 4) : '0;
      chk("rand_user_sel", 64'(bus.user_sel), 64'(esel));
      run_dr("rand_dr", op, $urandom_range(6, 40));
    end
    load_ir(4'b0110, cap);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    chk("pause_ir_state", 64'(bus.tap_state), 64'h0004);
    chk("pause_ir_keeps_ir", 64'(bus.ir), 64'h6);
    chk("pause_ir_tdo_en", 64'(bus.tdo_en), 64'h0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("back_to_shift_ir", 64'(bus.tap_state), 64'h0010);
    repeat (5) step(1'b1, 1'b0);
    chk("five_tms_tlr", 64'(bus.tap_state), 64'h8000);
    step(1'b1, 1'b0);
    chk("tlr_reload_ir", 64'(bus.ir), 64'h1);
    for (int t = 0; t < 4; t++) begin
      repeat ($urandom_range(5, 25)) step(1'($urandom), 1'($urandom));
      repeat (5) step(1'b1, 1'b0);
      chk("walk_five_tms_tlr", 64'(bus.tap_state), 64'h8000);
    end
    step(1'b0, 1'b0);
    load_ir(4'b0110, cap);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("pre_trst_tdo_en", 64'(bus.tdo_en), 64'h1);
    trst = 1'b1;
    #1;
    chk("trst_state", 64'(bus.tap_state), 64'h8000);
    chk("trst_ir", 64'(bus.ir), 64'h1);
    chk("trst_tdo_en", 64'(bus.tdo_en), 64'h0);
    chk("trst_tdo", 64'(bus.tdo), 64'h0);
    chk("trst_user_sel", 64'(bus.user_sel), 64'h0);
    chk("trst_shift_dr", 64'(bus.shift_dr), 64'h0);
    trst = 1'b0;
    step(1'b0, 1'b0);
    chk("post_trst_rti", 64'(bus.tap_state), 64'h4000);
    chk("post_trst_ir", 64'(bus.ir), 64'h1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
